// File: rtl/sat_hold_arbiter.sv
// sat_hold_arbiter
//
// Four-requester round-robin arbiter with a saturating hold timer. An idle
// arbiter grants the first requester found scanning from the round-robin
// pointer. The owner keeps the grant while it requests, for at most
// MAX_HOLD+1 cycles. It is then forced off, and a one-cycle timeout pulse is
// raised. Every release passes through at least one idle cycle with no grant.
// After any release the pointer moves to owner+1.
//
// Parameters
//   N         width of the hold timer
//   MAX_HOLD  hold timer saturation value, 1..2**N-1
//
// Ports
//   clk       clock, rising edge
//   n_reset   asynchronous active-low reset
//   req       [3:0] request vector, bit i = requester i
//   grant     [3:0] registered one-hot grant, or zero when idle
//   busy      registered, high whenever any grant bit is high
//   hold_cnt  [N-1:0] registered hold timer of the current owner
//   timeout   registered one-cycle pulse following a forced release
module sat_hold_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 2**N - 1
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic [3:0]   req,
  output logic [3:0]   grant,
  output logic         busy,
  output logic [N-1:0] hold_cnt,
  output logic         timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  localparam logic [N-1:0] MAX_CNT = N'(MAX_HOLD);

  state_t       state_reg,    state_next;
  logic [1:0]   ptr_reg,      ptr_next;
  logic [1:0]   owner_reg,    owner_next;
  logic [3:0]   grant_reg,    grant_next;
  logic         busy_reg,     busy_next;
  logic [N-1:0] hold_cnt_reg, hold_cnt_next;
  logic         timeout_reg,  timeout_next;

  // Candidate i of the scan is requester ptr+i (mod 4).
  logic [1:0] scan_idx [4];
  logic [3:0] scan_hit;
  logic [1:0] sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_scan
      assign scan_idx[gi] = ptr_reg + 2'(gi);
      assign scan_hit[gi] = req[scan_idx[gi]];
    end
  endgenerate

  // The loop walks from the last candidate to the first. An earlier hit
  // therefore overrides a later one, so the winner is the nearest requester
  // at or after ptr.
  always_comb begin
    sel = ptr_reg;
    for (int i = 3; i >= 0; i--) begin
      if (scan_hit[i]) sel = scan_idx[i];
    end
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    owner_next    = owner_reg;
    grant_next    = grant_reg;
    hold_cnt_next = hold_cnt_reg;
    timeout_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        grant_next    = 4'b0000;
        hold_cnt_next = '0;
        if (|req) begin
          owner_next = sel;
          grant_next = 4'b0001 << sel;
          state_next = OWNED;
        end
      end

      OWNED: begin
        // A dropped owner request is a normal release. This takes priority
        // over the saturation check, so a drop on the saturating edge does
        // not produce a timeout.
        if (!req[owner_reg]) begin
          grant_next    = 4'b0000;
          hold_cnt_next = '0;
          ptr_next      = owner_reg + 2'd1;
          state_next    = IDLE;
        end else if (hold_cnt_reg == MAX_CNT) begin
          grant_next    = 4'b0000;
          hold_cnt_next = '0;
          ptr_next      = owner_reg + 2'd1;
          timeout_next  = 1'b1;
          state_next    = IDLE;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end

      default: begin
        grant_next    = 4'b0000;
        hold_cnt_next = '0;
        state_next    = IDLE;
      end
    endcase

    busy_next = |grant_next;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg    <= IDLE;
      ptr_reg      <= 2'd0;
      owner_reg    <= 2'd0;
      grant_reg    <= 4'b0000;
      busy_reg     <= 1'b0;
      hold_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      owner_reg    <= owner_next;
      grant_reg    <= grant_next;
      busy_reg     <= busy_next;
      hold_cnt_reg <= hold_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign grant    = grant_reg;
  assign busy     = busy_reg;
  assign hold_cnt = hold_cnt_reg;
  assign timeout  = timeout_reg;

endmodule

// File: tb/tb_sat_hold_arbiter.sv
// tb_sat_hold_arbiter
//
// Directed bench for sat_hold_arbiter. It uses two instances: the default
// N=4 / MAX_HOLD=15 arbiter, and an N=4 / MAX_HOLD=1 arbiter for the
// shortest hold. Inputs change and outputs are sampled 1 time unit after
// each rising edge.
module tb_sat_hold_arbiter;

  logic       clk;
  logic       n_reset;
  logic [3:0] req;
  logic [3:0] grant;
  logic       busy;
  logic [3:0] hold_cnt;
  logic       timeout;

  logic [3:0] req1;
  logic [3:0] grant1;
  logic       busy1;
  logic [3:0] hold_cnt1;
  logic       timeout1;

  int total;
  int bad;

  sat_hold_arbiter #(.N(4)) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .req      (req),
    .grant    (grant),
    .busy     (busy),
    .hold_cnt (hold_cnt),
    .timeout  (timeout)
  );

  sat_hold_arbiter #(.N(4), .MAX_HOLD(1)) dut1 (
    .clk      (clk),
    .n_reset  (n_reset),
    .req      (req1),
    .grant    (grant1),
    .busy     (busy1),
    .hold_cnt (hold_cnt1),
    .timeout  (timeout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered on the first cycle of a full-length ownership. It follows the
  // ownership through hold_cnt 0..15 and the forced release, and returns on
  // the idle cycle that carries the timeout pulse.
  task automatic own_full(input logic [3:0] g);
    check_val("own_grant0", 8'(grant), 8'(g));
    check_val("own_hold0", 8'(hold_cnt), 8'd0);
    check_val("own_busy0", 8'(busy), 8'd1);
    check_val("own_tmo0", 8'(timeout), 8'd0);
    for (int k = 1; k <= 15; k++) begin
      step();
      check_val("own_hold", 8'(hold_cnt), 8'(k));
      check_val("own_grant", 8'(grant), 8'(g));
    end
    step();
    check_val("own_rel_grant", 8'(grant), 8'd0);
    check_val("own_rel_tmo", 8'(timeout), 8'd1);
    check_val("own_rel_hold", 8'(hold_cnt), 8'd0);
    check_val("own_rel_busy", 8'(busy), 8'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    total   = 0;
    bad     = 0;
    n_reset = 1'b0;
    req     = 4'b0000;
    req1    = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_grant", 8'(grant), 8'd0);
    check_val("rst_busy", 8'(busy), 8'd0);
    check_val("rst_hold", 8'(hold_cnt), 8'd0);
    check_val("rst_tmo", 8'(timeout), 8'd0);
    @(negedge clk);
    n_reset = 1'b1;
    step();

    // Case 1: req=0110 is held. From ptr=0 the grant goes to requester 1
    // one cycle later. The ownership times out, then requester 2 wins.
    req = 4'b0110;
    check_val("lat_pre_grant", 8'(grant), 8'd0);
    step();
    own_full(4'b0010);
    step();
    check_val("rr_next_grant", 8'(grant), 8'b0100);
    check_val("rr_next_tmo", 8'(timeout), 8'd0);
    req = 4'b0000;
    step();
    check_val("drop_grant", 8'(grant), 8'd0);
    check_val("drop_tmo", 8'(timeout), 8'd0);
    step();

    // Case 2: requester 0 holds for three cycles, then drops (ptr is 3 here).
    req = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("short_grant", 8'(grant), 8'b0001);
      check_val("short_hold", 8'(hold_cnt), 8'(k));
    end
    req = 4'b0000;
    step();
    check_val("short_rel_grant", 8'(grant), 8'd0);
    check_val("short_rel_tmo", 8'(timeout), 8'd0);

    // Case 3: all requesters held. The release above left ptr=1, so
    // ownership rotates 1,2,3,0,1 with a timeout gap after each one.
    req = 4'b1111;
    step();
    own_full(4'b0010);
    step();
    own_full(4'b0100);
    step();
    own_full(4'b1000);
    step();
    own_full(4'b0001);
    step();
    own_full(4'b0010);
    step();

    // Case 4: owner 2 drops its request on the edge where hold_cnt is 15.
    // This is a normal release, and the pointer moves on to 3.
    check_val("sat_drop_grant0", 8'(grant), 8'b0100);
    for (int k = 1; k <= 15; k++) begin
      step();
      check_val("sat_drop_hold", 8'(hold_cnt), 8'(k));
    end
    req = 4'b1011;
    step();
    check_val("sat_drop_grant", 8'(grant), 8'd0);
    check_val("sat_drop_tmo", 8'(timeout), 8'd0);
    check_val("sat_drop_hold0", 8'(hold_cnt), 8'd0);
    step();
    check_val("sat_drop_next", 8'(grant), 8'b1000);

    // Case 5: reset is asserted while hold_cnt is 7. The outputs must clear
    // with no clock edge.
    req = 4'b1000;
    repeat (7) step();
    check_val("mid_hold7", 8'(hold_cnt), 8'd7);
    n_reset = 1'b0;
    #1;
    check_val("mid_rst_grant", 8'(grant), 8'd0);
    check_val("mid_rst_hold", 8'(hold_cnt), 8'd0);
    check_val("mid_rst_tmo", 8'(timeout), 8'd0);
    check_val("mid_rst_busy", 8'(busy), 8'd0);
    // ptr was 3 before the reset. With req=1010, a scan from 3 would pick
    // requester 3, while a scan from the reset value 0 picks requester 1.
    req = 4'b1010;
    @(negedge clk);
    n_reset = 1'b1;
    step();
    check_val("post_rst_grant", 8'(grant), 8'b0010);
    req = 4'b0000;
    step();
    step();

    // Case 6: the MAX_HOLD=1 instance with req=0001 held.
    req1 = 4'b0001;
    step();
    check_val("mh1_grant_a", 8'(grant1), 8'b0001);
    check_val("mh1_hold_a", 8'(hold_cnt1), 8'd0);
    step();
    check_val("mh1_grant_b", 8'(grant1), 8'b0001);
    check_val("mh1_hold_b", 8'(hold_cnt1), 8'd1);
    step();
    check_val("mh1_gap_grant", 8'(grant1), 8'd0);
    check_val("mh1_gap_tmo", 8'(timeout1), 8'd1);
    check_val("mh1_gap_busy", 8'(busy1), 8'd0);
    step();
    check_val("mh1_regrant", 8'(grant1), 8'b0001);
    check_val("mh1_regrant_tmo", 8'(timeout1), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
